// File: rtl/hamming_secded_decoder.sv
// SECDED decoder: walks NUM_MSG encoded 16-bit words in memory and writes back 11-bit data + status.
// Optional error statistics counters are enabled with the HAMMING_DEC_STATS_EN macro.
module hamming_secded_decoder #(
  parameter int unsigned NUM_MSG  = 15,
  parameter int unsigned SRC_BASE = 30,
  parameter int unsigned DST_BASE = 0,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          done,
  output logic [3:0]    cnt_single,
  output logic [3:0]    cnt_double
);

  localparam int unsigned IW = $clog2(NUM_MSG + 1);

  // Hamming positions of d1..d11 inside the encoded word.
  localparam logic [3:0] DPOS [11] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12,
                                       4'd13, 4'd14, 4'd15};

  typedef enum logic [2:0] {StRdLo, StRdHi, StDecode, StWrLo, StWrHi, StDone} state_e;

  state_e         state_q;
  logic [IW-1:0]  idx_q;
  logic [15:0]    word_q;
  logic [7:0]     hi_q;

  logic [3:0]     syn;
  logic           par;
  logic           flip;
  logic [1:0]     dec_flag;
  logic [10:0]    dec_data;

  function automatic logic [AW-1:0] addr_of(input int unsigned base, input logic [IW-1:0] n,
                                            input logic hi);
    return AW'(base + 2 * 32'(n) + 32'(hi));
  endfunction

  always_comb begin
    syn[0]   = ^(word_q & 16'hAAAA);
    syn[1]   = ^(word_q & 16'hCCCC);
    syn[2]   = ^(word_q & 16'hF0F0);
    syn[3]   = ^(word_q & 16'hFF00);
    par      = ^word_q;
    // Odd parity means one flipped bit; syndrome 0 then points at p0, which carries no data.
    flip     = par && (syn != 4'd0);
    dec_flag = par ? 2'b01 : ((syn != 4'd0) ? 2'b10 : 2'b00);
  end

  for (genvar j = 0; j < 11; j++) begin : g_data
    assign dec_data[j] = word_q[DPOS[j]] ^ (flip && (syn == DPOS[j]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRdLo;
      idx_q     <= '0;
      word_q    <= '0;
      hi_q      <= '0;
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
      mem_addr  <= addr_of(SRC_BASE, '0, 1'b0);
    end else begin
      // Outputs are registered, so each branch presents the bus for the state it enters.
      unique case (state_q)
        StRdLo: begin
          word_q[7:0] <= mem_rdata;
          mem_addr    <= addr_of(SRC_BASE, idx_q, 1'b1);
          state_q     <= StRdHi;
        end
        StRdHi: begin
          word_q[15:8] <= mem_rdata;
          mem_addr     <= addr_of(DST_BASE, idx_q, 1'b0);
          state_q      <= StDecode;
        end
        StDecode: begin
          hi_q      <= {dec_flag, 3'b000, dec_data[10:8]};
          mem_addr  <= addr_of(DST_BASE, idx_q, 1'b0);
          mem_wdata <= dec_data[7:0];
          mem_wr_en <= 1'b1;
          state_q   <= StWrLo;
        end
        StWrLo: begin
          mem_addr  <= addr_of(DST_BASE, idx_q, 1'b1);
          mem_wdata <= hi_q;
          state_q   <= StWrHi;
        end
        StWrHi: begin
          mem_wr_en <= 1'b0;
          mem_wdata <= '0;
          if (idx_q == IW'(NUM_MSG - 1)) begin
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q    <= idx_q + 1'b1;
            mem_addr <= addr_of(SRC_BASE, idx_q + 1'b1, 1'b0);
            state_q  <= StRdLo;
          end
        end
        StDone: begin
          mem_wr_en <= 1'b0;
        end
        default: state_q <= StDone;
      endcase
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic [3:0] cnt_single_q;
  logic [3:0] cnt_double_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else if (state_q == StWrHi) begin
      if (hi_q[7:6] == 2'b01 && cnt_single_q != 4'hF) cnt_single_q <= cnt_single_q + 4'd1;
      if (hi_q[7:6] == 2'b10 && cnt_double_q != 4'hF) cnt_double_q <= cnt_double_q + 4'd1;
    end
  end

  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
`else
  assign cnt_single = 4'd0;
  assign cnt_double = 4'd0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: memory model, behavioural decode model, per-cycle bus checks.
module tb_hamming_secded_decoder;

  localparam int NMSG = 15;
  localparam int SRC  = 30;
  localparam int DST  = 0;
  localparam int RUN  = 5 * NMSG;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       done;
  logic [3:0] cnt_single;
  logic [3:0] cnt_double;

  logic [7:0]  mem [256];
  logic [15:0] src_word [NMSG];

  int n_pass = 0;
  int n_total = 0;

  hamming_secded_decoder #(
    .NUM_MSG (NMSG),
    .SRC_BASE(SRC),
    .DST_BASE(DST),
    .AW      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .cnt_single(cnt_single),
    .cnt_double(cnt_double)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decode straight from the syndrome/parity rules: returns {high byte, low byte}.
  function automatic logic [15:0] ref_dec(input logic [15:0] w_in);
    logic [15:0] w;
    logic [10:0] d;
    logic [1:0]  f;
    int s, p, j;
    w = w_in; s = 0; p = 0; j = 0; d = '0;
    for (int k = 1; k < 16; k++) if (w[k]) s = s ^ k;
    for (int k = 0; k < 16; k++) p = p ^ int'(w[k]);
    if (p == 1) begin
      f = 2'b01;
      if (s != 0) w[s] = ~w[s];
    end else if (s != 0) f = 2'b10;
    else f = 2'b00;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        d[j] = w[k];
        j++;
      end
    end
    return {f, 3'b000, d};
  endfunction

  // Valid codeword from random bits, then nerr (0..2) distinct bit flips.
  function automatic logic [15:0] mk(input logic [15:0] r, input int nerr);
    logic [15:0] w;
    int s, a, b;
    w = r; s = 0;
    for (int k = 1; k < 16; k++) if (w[k]) s = s ^ k;
    if (s != 0) w[s] = ~w[s];
    w[0] = w[0] ^ (^w);
    a = int'($urandom_range(0, 15));
    b = (a + 1 + int'($urandom_range(0, 14))) % 16;
    if (nerr >= 1) w[a] = ~w[a];
    if (nerr >= 2) w[b] = ~w[b];
    return w;
  endfunction

  // Per-cycle model: pc = rising edges with reset low since the last reset edge.
  int  pc = 0;
  bit  started = 1'b0;
  bit  rst_edge = 1'b0;
  int  exp_s = 0;
  int  exp_d = 0;

  always @(posedge clk) begin
    if (reset) begin
      pc = 0; started = 1'b1; rst_edge = 1'b1; exp_s = 0; exp_d = 0;
    end else if (started) begin
      rst_edge = 1'b0;
      if (pc < RUN && pc % 5 == 4) begin
        logic [15:0] r;
        r = ref_dec(src_word[pc / 5]);
        if (r[15:14] == 2'b01 && exp_s < 15) exp_s++;
        if (r[15:14] == 2'b10 && exp_d < 15) exp_d++;
      end
      pc++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (rst_edge) chk("reset_wdata", {24'd0, mem_wdata}, 32'd0);
      if (pc >= RUN) begin
        chk("done_high", {31'd0, done}, 32'd1);
        chk("idle_wr_en", {31'd0, mem_wr_en}, 32'd0);
      end else begin
        int m, ph;
        logic [15:0] r;
        m = pc / 5; ph = pc % 5;
        r = ref_dec(src_word[m]);
        chk("done_low", {31'd0, done}, 32'd0);
        chk("wr_en", {31'd0, mem_wr_en}, (ph == 3 || ph == 4) ? 32'd1 : 32'd0);
        if (ph == 0) chk("rd_lo_addr", {24'd0, mem_addr}, 32'((SRC + 2 * m) % 256));
        if (ph == 1) chk("rd_hi_addr", {24'd0, mem_addr}, 32'((SRC + 2 * m + 1) % 256));
        if (ph == 3) begin
          chk("wr_lo_addr", {24'd0, mem_addr}, 32'((DST + 2 * m) % 256));
          chk("wr_lo_data", {24'd0, mem_wdata}, {24'd0, r[7:0]});
        end
        if (ph == 4) begin
          chk("wr_hi_addr", {24'd0, mem_addr}, 32'((DST + 2 * m + 1) % 256));
          chk("wr_hi_data", {24'd0, mem_wdata}, {24'd0, r[15:8]});
        end
      end
`ifdef HAMMING_DEC_STATS_EN
      chk("cnt_single", {28'd0, cnt_single}, 32'(exp_s));
      chk("cnt_double", {28'd0, cnt_double}, 32'(exp_d));
`else
      chk("cnt_single_off", {28'd0, cnt_single}, 32'd0);
      chk("cnt_double_off", {28'd0, cnt_double}, 32'd0);
`endif
    end
  end

  task automatic load_src();
    for (int i = 0; i < NMSG; i++) begin
      mem[SRC + 2 * i]     = src_word[i][7:0];
      mem[SRC + 2 * i + 1] = src_word[i][15:8];
    end
    for (int i = 0; i < 2 * NMSG; i++) mem[DST + i] = 8'hAA;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2 * RUN) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", {31'd0, done}, 32'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NMSG; i++) begin
      logic [15:0] r;
      r = ref_dec(src_word[i]);
      chk("mem_lo", {24'd0, mem[DST + 2 * i]}, {24'd0, r[7:0]});
      chk("mem_hi", {24'd0, mem[DST + 2 * i + 1]}, {24'd0, r[15:8]});
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    reset = 1'b1;
    load_src();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Model pins against hand-decoded words.
    chk("model_clean", {16'd0, ref_dec(16'hFFFF)}, 32'h07FF);
    chk("model_single", {16'd0, ref_dec(16'hFFDF)}, 32'h47FF);
    chk("model_p0", {16'd0, ref_dec(16'hFFFE)}, 32'h47FF);
    chk("model_double", {16'd0, ref_dec(16'hFFFC)}, 32'h87FF);

    // Run 1: literal slots followed by random codewords with 0..2 errors.
    src_word[0] = 16'hFFFF; src_word[1] = 16'hFFDF;
    src_word[2] = 16'hFFFE; src_word[3] = 16'hFFFC;
    src_word[4] = 16'h0000;
    for (int i = 5; i < NMSG; i++)
      src_word[i] = mk(16'($urandom), int'($urandom_range(0, 2)));
    start_run();
    wait_done();
    check_outputs();
    chk("lit_clean_hi", {24'd0, mem[1]}, 32'h07);
    chk("lit_clean_lo", {24'd0, mem[0]}, 32'hFF);
    chk("lit_single_hi", {24'd0, mem[3]}, 32'h47);
    chk("lit_p0_hi", {24'd0, mem[5]}, 32'h47);
    chk("lit_double_hi", {24'd0, mem[7]}, 32'h87);
    chk("lit_double_lo", {24'd0, mem[6]}, 32'hFF);

    // Run 2: all-zero words.
    for (int i = 0; i < NMSG; i++) src_word[i] = 16'h0000;
    start_run();
    wait_done();
    for (int i = 0; i < 2 * NMSG; i++) chk("zero_out", {24'd0, mem[DST + i]}, 32'h00);

    // Run 3: one single and one double error, reset pulsed mid-run.
    src_word[0] = 16'hFFDF; src_word[1] = 16'hFFFC;
    start_run();
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_done();
    check_outputs();
    chk("rerun_single_hi", {24'd0, mem[1]}, 32'h47);
    chk("rerun_double_hi", {24'd0, mem[3]}, 32'h87);
`ifdef HAMMING_DEC_STATS_EN
    chk("lit_cnt_single", {28'd0, cnt_single}, 32'd1);
    chk("lit_cnt_double", {28'd0, cnt_double}, 32'd1);
`else
    chk("lit_cnt_single_off", {28'd0, cnt_single}, 32'd0);
    chk("lit_cnt_double_off", {28'd0, cnt_double}, 32'd0);
`endif

    // Run 4: every word carries a single error.
    for (int i = 0; i < NMSG; i++) src_word[i] = mk(16'($urandom), 1);
    start_run();
    wait_done();
    check_outputs();
`ifdef HAMMING_DEC_STATS_EN
    chk("all_single_cnt", {28'd0, cnt_single}, 32'd15);
`else
    chk("all_single_cnt_off", {28'd0, cnt_single}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hamming_secded_decoder.md
# hamming_secded_decoder

Hardware decode stage that sits directly downstream of the program-1 parity encoder in the data-memory pipeline. Walks the 15 encoded 16-bit words the encoder leaves in data memory, computes the Hamming syndrome and overall parity, corrects single-bit errors, and flags double-bit errors. Writes each recovered 11-bit message plus a 2-bit status back to memory.

## Interface
Parameters:
- NUM_MSG, 15, number of messages processed per run
- SRC_BASE, 30, byte address of first encoded word (low byte; high byte at +1)
- DST_BASE, 0, byte address of first decoded output (low byte; high byte at +1)
- AW, 8, memory address width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; also the start request
- mem_addr  out  AW  byte address to data memory
- mem_wr_en  out  1  write strobe, one byte per asserted cycle
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, combinational from mem_addr (async read)
- done  out  1  high when all NUM_MSG messages are written; held until next reset
- cnt_single  out  4  corrected-single-error count (see Configuration)
- cnt_double  out  4  detected-double-error count (see Configuration)

## Operation
- Encoded word layout, bit 15..0: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}. Hamming position k = bit k for k = 1..15; bit 0 = p0 (overall parity).
- Syndrome S[3:0]: S[i] = XOR of all bits k in 1..15 with k[i]=1. P = XOR of all 16 bits.
- Classification:
  - S=0, P=0: no error, F=2'b00.
  - P=1: single error, F=2'b01. If S≠0, invert bit S; if S=0, the error is in p0 and data is unchanged.
  - S≠0, P=0: double error, F=2'b10; data extracted uncorrected.
- Output bytes: high = {F[1:0], 3'b000, d11, d10, d9}; low = {d8..d1}.
- FSM states: RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE.
  - RD_LO: addr = SRC_BASE+2i, capture low byte.
  - RD_HI: addr = SRC_BASE+2i+1, capture high byte.
  - DECODE: register syndrome, F and corrected data.
  - WR_LO: write low byte to DST_BASE+2i.
  - WR_HI: write high byte to DST_BASE+2i+1; if i = NUM_MSG-1, go to DONE, else i++ and go to RD_LO.
  - DONE: terminal; mem_wr_en = 0.
- Message index i is ceil(log2(NUM_MSG+1)) bits wide. Address arithmetic is modulo 2^AW (wraps; no error).

## Timing
- While reset is high: state = RD_LO, i = 0, done = 0, mem_wr_en = 0, mem_addr = SRC_BASE, mem_wdata = 0, counters = 0.
- Processing starts the first cycle after reset falls. Each message takes 5 cycles, so a run is 5·NUM_MSG cycles.
- done is registered and rises 5·NUM_MSG cycles after reset deasserts (cycle 76 for the default). It stays high until reset.
- mem_wr_en is high only in WR_LO and WR_HI, exactly one cycle each.
- Reset asserted mid-run: abort at the next edge and restart from message 0 after release. Previously written outputs are overwritten by the restarted run. Counters clear.
- Reset held multiple cycles: no memory writes occur.

## Configuration
- Macro: HAMMING_DEC_STATS_EN.
- Defined: cnt_single increments on each F=01 message and cnt_double on each F=10 message, in the WR_HI cycle. Both saturate at 15 and clear on reset.
- Undefined: cnt_single and cnt_double are tied to 0, and no counter logic is synthesized. Decode behaviour is identical.

## Test plan
- Clean word 16'hFFFF at addr 30/31 (high byte 0xFF at 31) -> addr 1 = 8'h07, addr 0 = 8'hFF (F=00).
- Single data error 16'hFFDF (bit 5 flipped) -> addr 1 = 8'h47, addr 0 = 8'hFF; cnt_single = 1 with HAMMING_DEC_STATS_EN.
- p0-only error 16'hFFFE -> 8'h47 / 8'hFF; double error 16'hFFFC -> 8'h87 / 8'hFF; cnt_double = 1.
- All 15 slots hold 16'h0000 -> all 30 output bytes are 8'h00. done rises exactly 75 cycles after reset deasserts and holds.
- Reset pulsed at cycle 20 of a run -> no write strobes during reset; full correct rerun; done only 75 cycles after second release.
- Macro undefined, 15 single-error words -> outputs correct, cnt_single = cnt_double = 0.
